instr_encoder: RTL and testbench

INSTR_ENCODER -- requirements
Module: instr_encoder

---
 rtl/instr_encoder_pkg.sv | 67 ++++++
 rtl/instr_encoder_if.sv | 33 +++
 rtl/instr_encode_comb.sv | 56 +++++
 rtl/instr_encoder.sv | 153 +++++++++++++++
 tb/tb_instr_encoder.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/instr_encoder_pkg.sv
// Shared definitions for the instruction encoder: op_sel mnemonics, MIPS opcode/funct
// codes, the NOP word and the descriptor record passed to the encoder.
package instr_encoder_pkg;

  typedef enum logic [4:0] {
    OP_ADD  = 5'd0,
    OP_SUB  = 5'd1,
    OP_AND  = 5'd2,
    OP_OR   = 5'd3,
    OP_SLT  = 5'd4,
    OP_SGT  = 5'd5,
    OP_NOR  = 5'd6,
    OP_XOR  = 5'd7,
    OP_SLL  = 5'd8,
    OP_SRL  = 5'd9,
    OP_JR   = 5'd10,
    OP_ADDI = 5'd11,
    OP_LW   = 5'd12,
    OP_SW   = 5'd13,
    OP_BEQ  = 5'd14,
    OP_BNE  = 5'd15,
    OP_JAL  = 5'd16,
    OP_ORI  = 5'd17,
    OP_XORI = 5'd18,
    OP_ANDI = 5'd19,
    OP_SLTI = 5'd20,
    OP_J    = 5'd21
  } op_e;

  localparam logic [5:0] OPC_RTYPE = 6'h00;
  localparam logic [5:0] OPC_ADDI  = 6'h08;
  localparam logic [5:0] OPC_LW    = 6'h23;
  localparam logic [5:0] OPC_SW    = 6'h2B;
  localparam logic [5:0] OPC_BEQ   = 6'h04;
  localparam logic [5:0] OPC_BNE   = 6'h05;
  localparam logic [5:0] OPC_ORI   = 6'h0D;
  localparam logic [5:0] OPC_XORI  = 6'h16;
  localparam logic [5:0] OPC_ANDI  = 6'h0C;
  localparam logic [5:0] OPC_SLTI  = 6'h0A;
  localparam logic [5:0] OPC_J     = 6'h02;
  localparam logic [5:0] OPC_JAL   = 6'h03;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;
  localparam logic [5:0] FN_SGT = 6'h14;
  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_NOR = 6'h27;
  localparam logic [5:0] FN_XOR = 6'h15;
  localparam logic [5:0] FN_JR  = 6'h08;

  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  typedef struct packed {
    logic [4:0]  op_sel;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [15:0] imm;
    logic [25:0] target;
  } desc_t;

endpackage

// File: rtl/instr_encoder_if.sv
// Descriptor input, instruction-memory write port and status bundle of instr_encoder.
interface instr_encoder_if #(
  parameter int ADDR_W = 10
);
  logic              start;
  logic              in_valid;
  logic              in_ready;
  logic [4:0]        op_sel;
  logic [4:0]        rs;
  logic [4:0]        rt;
  logic [4:0]        rd;
  logic [4:0]        shamt;
  logic [15:0]       imm;
  logic [25:0]       target;
  logic              last;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              busy;
  logic              done;
  logic [1:0]        err;
  logic [ADDR_W:0]   count;

  modport master (
    output start, in_valid, op_sel, rs, rt, rd, shamt, imm, target, last,
    input  in_ready, imem_we, imem_addr, imem_wdata, busy, done, err, count
  );

  modport slave (
    input  start, in_valid, op_sel, rs, rt, rd, shamt, imm, target, last,
    output in_ready, imem_we, imem_addr, imem_wdata, busy, done, err, count
  );
endinterface

// File: rtl/instr_encode_comb.sv
// Pure combinational translation of one op descriptor into a 32-bit MIPS word,
// with a legal flag that drops for op_sel codes outside the mnemonic table.
module instr_encode_comb
  import instr_encoder_pkg::*;
(
  input  desc_t       desc,
  output logic [31:0] word,
  output logic        legal
);

  function automatic logic [31:0] r_word(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [4:0] shamt,
                                         input logic [5:0] funct);
    return {OPC_RTYPE, rs, rt, rd, shamt, funct};
  endfunction

  function automatic logic [31:0] i_word(input logic [5:0] opc, input desc_t d);
    return {opc, d.rs, d.rt, d.imm};
  endfunction

  function automatic logic [31:0] j_word(input logic [5:0] opc, input logic [25:0] target);
    return {opc, target};
  endfunction

  // Shifts ignore rs and JR ignores rt/rd/shamt, so those fields are zeroed in the word.
  always_comb begin
    word  = NOP_WORD;
    legal = 1'b1;
    case (desc.op_sel)
      OP_ADD:  word = r_word(desc.rs, desc.rt, desc.rd, desc.shamt, FN_ADD);
      OP_SUB:  word = r_word(desc.rs, desc.rt, desc.rd, desc.shamt, FN_SUB);
      OP_AND:  word = r_word(desc.rs, desc.rt, desc.rd, desc.shamt, FN_AND);
      OP_OR:   word = r_word(desc.rs, desc.rt, desc.rd, desc.shamt, FN_OR);
      OP_SLT:  word = r_word(desc.rs, desc.rt, desc.rd, desc.shamt, FN_SLT);
      OP_SGT:  word = r_word(desc.rs, desc.rt, desc.rd, desc.shamt, FN_SGT);
      OP_NOR:  word = r_word(desc.rs, desc.rt, desc.rd, desc.shamt, FN_NOR);
      OP_XOR:  word = r_word(desc.rs, desc.rt, desc.rd, desc.shamt, FN_XOR);
      OP_SLL:  word = r_word(5'd0, desc.rt, desc.rd, desc.shamt, FN_SLL);
      OP_SRL:  word = r_word(5'd0, desc.rt, desc.rd, desc.shamt, FN_SRL);
      OP_JR:   word = r_word(desc.rs, 5'd0, 5'd0, 5'd0, FN_JR);
      OP_ADDI: word = i_word(OPC_ADDI, desc);
      OP_LW:   word = i_word(OPC_LW, desc);
      OP_SW:   word = i_word(OPC_SW, desc);
      OP_BEQ:  word = i_word(OPC_BEQ, desc);
      OP_BNE:  word = i_word(OPC_BNE, desc);
      OP_ORI:  word = i_word(OPC_ORI, desc);
      OP_XORI: word = i_word(OPC_XORI, desc);
      OP_ANDI: word = i_word(OPC_ANDI, desc);
      OP_SLTI: word = i_word(OPC_SLTI, desc);
      OP_JAL:  word = j_word(OPC_JAL, desc.target);
      OP_J:    word = j_word(OPC_J, desc.target);
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Load-session controller: accepts op descriptors, encodes them and writes them to
// consecutive instruction-memory addresses. Define INSTR_ENCODER_NOP_PAD_EN to append two NOPs.
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter int BASE_ADDR = 0
) (
  input  logic           clk,
  input  logic           rst,
  instr_encoder_if.slave bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_DONE = 2'd3;
`ifdef INSTR_ENCODER_NOP_PAD_EN
  localparam logic [1:0] S_PAD       = 2'd2;
  localparam logic [1:0] S_LOAD_EXIT = S_PAD;
`else
  localparam logic [1:0] S_LOAD_EXIT = S_DONE;
`endif

  localparam logic [ADDR_W-1:0] ADDR_MAX  = '1;
  localparam logic [ADDR_W-1:0] ADDR_BASE = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W+1)'(1);

  logic [1:0]        state;
  logic [ADDR_W-1:0] waddr;
  logic [1:0]        err_q;
  logic [ADDR_W:0]   count_q;
`ifdef INSTR_ENCODER_NOP_PAD_EN
  logic              full;
  logic              pad_cnt;
`endif

  desc_t             desc_p0;
  logic [31:0]       word_p0;
  logic              legal_p0;
  logic              accept_p0;
  logic              at_max_p0;

  logic              vld_p1;
  logic [31:0]       wdata_p1;
  logic [ADDR_W-1:0] addr_p1;

  // Stage p0: descriptor capture and encode
  always_comb begin
    desc_p0        = '0;
    desc_p0.op_sel = bus.op_sel;
    desc_p0.rs     = bus.rs;
    desc_p0.rt     = bus.rt;
    desc_p0.rd     = bus.rd;
    desc_p0.shamt  = bus.shamt;
    desc_p0.imm    = bus.imm;
    desc_p0.target = bus.target;
  end

  instr_encode_comb u_encode (
    .desc  (desc_p0),
    .word  (word_p0),
    .legal (legal_p0)
  );

  assign accept_p0 = bus.in_valid & (state == S_LOAD);
  assign at_max_p0 = (waddr == ADDR_MAX);

  // Stage p1: registered memory write and session control
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      waddr    <= ADDR_BASE;
      err_q    <= 2'b00;
      count_q  <= '0;
      vld_p1   <= 1'b0;
      wdata_p1 <= NOP_WORD;
      addr_p1  <= ADDR_BASE;
`ifdef INSTR_ENCODER_NOP_PAD_EN
      full     <= 1'b0;
      pad_cnt  <= 1'b0;
`endif
    end else begin
      vld_p1 <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            state   <= S_LOAD;
            waddr   <= ADDR_BASE;
            err_q   <= 2'b00;
            count_q <= '0;
`ifdef INSTR_ENCODER_NOP_PAD_EN
            full    <= 1'b0;
`endif
          end
        end
        S_LOAD: begin
          if (accept_p0) begin
            if (legal_p0) begin
              vld_p1   <= 1'b1;
              wdata_p1 <= word_p0;
              addr_p1  <= waddr;
              count_q  <= count_q + CNT_ONE;
              // The top address is written once; the session then closes instead of wrapping.
              if (at_max_p0) begin
                if (!bus.last) err_q[1] <= 1'b1;
`ifdef INSTR_ENCODER_NOP_PAD_EN
                full <= 1'b1;
`endif
              end else begin
                waddr <= waddr + ADDR_ONE;
              end
            end else begin
              err_q[0] <= 1'b1;
            end
            if (bus.last || (legal_p0 && at_max_p0)) state <= S_LOAD_EXIT;
          end
        end
`ifdef INSTR_ENCODER_NOP_PAD_EN
        S_PAD: begin
          if (!full) begin
            vld_p1   <= 1'b1;
            wdata_p1 <= NOP_WORD;
            addr_p1  <= waddr;
            count_q  <= count_q + CNT_ONE;
            if (at_max_p0) full  <= 1'b1;
            else           waddr <= waddr + ADDR_ONE;
          end
          if (full || pad_cnt || at_max_p0) begin
            state   <= S_DONE;
            pad_cnt <= 1'b0;
          end else begin
            pad_cnt <= 1'b1;
          end
        end
`endif
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // The write strobe is masked by rst so a write already staged is not issued while aborting.
  assign bus.imem_we    = vld_p1 & ~rst;
  assign bus.imem_addr  = addr_p1;
  assign bus.imem_wdata = wdata_p1;
  assign bus.in_ready   = (state == S_LOAD);
  assign bus.busy       = (state != S_IDLE);
  assign bus.done       = (state == S_DONE);
  assign bus.err        = err_q;
  assign bus.count      = count_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: directed and random load sessions on a 10-bit and a 2-bit
// address instance, checked against a behavioural session model.
module tb_instr_encoder;

`ifdef INSTR_ENCODER_NOP_PAD_EN
  localparam bit PAD_EN = 1'b1;
`else
  localparam bit PAD_EN = 1'b0;
`endif

  typedef struct {
    int op; int rs; int rt; int rd; int sh; int imm; int tgt; bit last;
  } d_t;
  typedef struct {
    int addr; logic [31:0] data;
  } w_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start_a = 1'b0, start_b = 1'b0, in_valid = 1'b0, last = 1'b0;
  logic [4:0] op_sel = '0, rs = '0, rt = '0, rd = '0, shamt = '0;
  logic [15:0] imm = '0;
  logic [25:0] target = '0;

  int n_chk = 0;
  int n_err = 0;
  d_t stim[$];
  w_t exp_w[$];
  w_t cap_a[$], cap_b[$];
  w_t wa, wb;
  int done_a = 0, done_b = 0;

  always #5 clk = ~clk;

  instr_encoder_if #(.ADDR_W(10)) ia ();
  instr_encoder_if #(.ADDR_W(2))  ib ();

  assign ia.start = start_a;  assign ib.start = start_b;
  assign ia.in_valid = in_valid; assign ib.in_valid = in_valid;
  assign ia.op_sel = op_sel;  assign ib.op_sel = op_sel;
  assign ia.rs = rs;          assign ib.rs = rs;
  assign ia.rt = rt;          assign ib.rt = rt;
  assign ia.rd = rd;          assign ib.rd = rd;
  assign ia.shamt = shamt;    assign ib.shamt = shamt;
  assign ia.imm = imm;        assign ib.imm = imm;
  assign ia.target = target;  assign ib.target = target;
  assign ia.last = last;      assign ib.last = last;

  instr_encoder #(.ADDR_W(10), .BASE_ADDR(0)) dut   (.clk(clk), .rst(rst), .bus(ia));
  instr_encoder #(.ADDR_W(2),  .BASE_ADDR(0)) dut_s (.clk(clk), .rst(rst), .bus(ib));

  always @(negedge clk) begin
    if (ia.imem_we === 1'b1) begin
      wa.addr = int'(ia.imem_addr); wa.data = ia.imem_wdata; cap_a.push_back(wa);
    end
    if (ib.imem_we === 1'b1) begin
      wb.addr = int'(ib.imem_addr); wb.data = ib.imem_wdata; cap_b.push_back(wb);
    end
    if (ia.done === 1'b1) done_a++;
    if (ib.done === 1'b1) done_b++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] ref_word(input d_t d);
    int fn[11]  = '{'h20, 'h22, 'h24, 'h25, 'h2A, 'h14, 'h27, 'h15, 'h00, 'h02, 'h08};
    int opc[22] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
                    'h08, 'h23, 'h2B, 'h04, 'h05, 'h03, 'h0D, 'h16, 'h0C, 'h0A, 'h02};
    int r_s = d.rs, r_t = d.rt, r_d = d.rd, s_h = d.sh;
    if (d.op <= 10) begin
      if (d.op == 8 || d.op == 9) r_s = 0;
      if (d.op == 10) begin r_t = 0; r_d = 0; s_h = 0; end
      return 32'((r_s << 21) | (r_t << 16) | (r_d << 11) | (s_h << 6) | fn[d.op]);
    end
    if (d.op == 16 || d.op == 21) return 32'((opc[d.op] << 26) | d.tgt);
    return 32'((opc[d.op] << 26) | (d.rs << 21) | (d.rt << 16) | d.imm);
  endfunction

  // Session model: which descriptors get accepted, which words land where, final err.
  function automatic void model(input int aw, output int n_acc, output logic [1:0] e);
    int addr = 0;
    int maxa = (1 << aw) - 1;
    bit ended = 0;
    w_t w;
    exp_w.delete();
    n_acc = 0;
    e = 2'b00;
    foreach (stim[i]) begin
      if (ended) break;
      n_acc++;
      if (stim[i].op > 21) e[0] = 1'b1;
      else begin
        w.addr = addr; w.data = ref_word(stim[i]); exp_w.push_back(w);
        if (addr == maxa) begin ended = 1; if (!stim[i].last) e[1] = 1'b1; end
        addr++;
      end
      if (stim[i].last) ended = 1;
    end
    if (PAD_EN) for (int k = 0; k < 2; k++) if (addr <= maxa) begin
      w.addr = addr; w.data = 32'h0; exp_w.push_back(w); addr++;
    end
  endfunction

  function automatic void add(input int op, input int r_s, input int r_t, input int r_d,
                              input int s_h, input int im, input int tg, input bit lst);
    d_t d;
    d.op = op; d.rs = r_s; d.rt = r_t; d.rd = r_d; d.sh = s_h; d.imm = im; d.tgt = tg; d.last = lst;
    stim.push_back(d);
  endfunction

  task automatic gen_random(input int n, input int max_op);
    stim.delete();
    for (int k = 0; k < n; k++)
      add($urandom_range(0, max_op), $urandom_range(0, 31), $urandom_range(0, 31),
          $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 65535),
          $urandom_range(0, 26'h3FFFFFF), k == n - 1);
  endtask

  task automatic run_session(input bit sel, input string tag);
    int n_acc_exp, acc, i, guard;
    logic [1:0] e_exp;
    logic rdy;
    w_t got[$];
    model(sel ? 2 : 10, n_acc_exp, e_exp);
    cap_a.delete(); cap_b.delete(); done_a = 0; done_b = 0;
    @(posedge clk); #2;
    if (sel) start_b = 1'b1; else start_a = 1'b1;
    @(posedge clk); #2;
    start_a = 1'b0; start_b = 1'b0;
    chk({tag, " count cleared"}, sel ? 64'(ib.count) : 64'(ia.count), 0);
    chk({tag, " err cleared"}, sel ? ib.err : ia.err, 2'b00);
    acc = 0; i = 0; guard = 0;
    while (i < stim.size() && guard < 500) begin
      guard++;
      if ($urandom_range(0, 3) == 0) begin
        in_valid = 1'b0; @(posedge clk); #2; continue;
      end
      rdy = sel ? ib.in_ready : ia.in_ready;
      if (!rdy) break;
      op_sel = 5'(stim[i].op); rs = 5'(stim[i].rs); rt = 5'(stim[i].rt); rd = 5'(stim[i].rd);
      shamt = 5'(stim[i].sh); imm = 16'(stim[i].imm); target = 26'(stim[i].tgt);
      last = stim[i].last; in_valid = 1'b1;
      @(posedge clk); #2;
      in_valid = 1'b0; last = 1'b0;
      acc++; i++;
    end
    guard = 0;
    while ((sel ? ib.busy : ia.busy) === 1'b1 && guard < 40) begin
      @(posedge clk); #2; guard++;
    end
    chk({tag, " session ends"}, guard < 40, 1'b1);
    got = sel ? cap_b : cap_a;
    chk({tag, " accepted"}, acc, n_acc_exp);
    chk({tag, " writes"}, got.size(), exp_w.size());
    for (int k = 0; k < exp_w.size() && k < got.size(); k++) begin
      chk($sformatf("%s addr[%0d]", tag, k), got[k].addr, exp_w[k].addr);
      chk($sformatf("%s data[%0d]", tag, k), got[k].data, exp_w[k].data);
    end
    chk({tag, " err"}, sel ? ib.err : ia.err, e_exp);
    chk({tag, " count"}, sel ? 64'(ib.count) : 64'(ia.count), exp_w.size());
    chk({tag, " done pulses"}, sel ? done_b : done_a, 1);
  endtask

  task automatic check_reset_a(input string tag);
    chk({tag, " in_ready"}, ia.in_ready, 1'b0);
    chk({tag, " imem_we"}, ia.imem_we, 1'b0);
    chk({tag, " imem_addr"}, ia.imem_addr, 10'd0);
    chk({tag, " imem_wdata"}, ia.imem_wdata, 32'h0);
    chk({tag, " busy"}, ia.busy, 1'b0);
    chk({tag, " done"}, ia.done, 1'b0);
    chk({tag, " err"}, ia.err, 2'b00);
    chk({tag, " count"}, ia.count, 11'd0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    check_reset_a("reset");
    chk("reset small busy", ib.busy, 1'b0);

    stim.delete(); add(0, 1, 2, 3, 0, 0, 0, 1);
    run_session(0, "add_last");
    chk("add_last word", cap_a.size() > 0 ? cap_a[0].data : 32'hx, 32'h00221820);

    stim.delete(); add(12, 29, 8, 0, 0, 4, 0, 0); add(16, 0, 0, 0, 0, 0, 'h10, 1);
    run_session(0, "lw_jal");
    chk("lw word", cap_a.size() > 0 ? cap_a[0].data : 32'hx, 32'h8FA80004);
    chk("jal word", cap_a.size() > 1 ? cap_a[1].data : 32'hx, 32'h0C000010);

    stim.delete(); add(8, 7, 5, 4, 2, 0, 0, 1);
    run_session(0, "sll");
    chk("sll word", cap_a.size() > 0 ? cap_a[0].data : 32'hx, 32'h00052080);

    stim.delete(); add(0, 1, 2, 3, 0, 0, 0, 0); add(31, 1, 1, 1, 1, 1, 1, 0);
    add(0, 4, 5, 6, 0, 0, 0, 1);
    run_session(0, "illegal");
    chk("illegal err", ia.err, 2'b01);
    chk("illegal 2nd addr", cap_a.size() > 1 ? cap_a[1].addr : -1, 1);

    stim.delete(); for (int k = 0; k < 5; k++) add(0, k, k + 1, k + 2, 0, 0, 0, 0);
    run_session(1, "overflow");
    chk("overflow err", ib.err, 2'b10);
    chk("overflow last addr", cap_b.size() > 3 ? cap_b[3].addr : -1, 3);

    for (int s = 0; s < 6; s++) begin
      gen_random($urandom_range(1, 8), 27);
      run_session(0, $sformatf("rand_a%0d", s));
      gen_random($urandom_range(1, 6), 23);
      run_session(1, $sformatf("rand_b%0d", s));
    end

    cap_a.delete();
    @(posedge clk); #2 start_a = 1'b1;
    @(posedge clk); #2 start_a = 1'b0;
    op_sel = 5'd0; rs = 5'd1; rt = 5'd2; rd = 5'd3; shamt = 5'd0; last = 1'b1; in_valid = 1'b1;
    @(posedge clk); #2 in_valid = 1'b0; last = 1'b0; rst = 1'b1;
    #1 chk("abort we during rst", ia.imem_we, 1'b0);
    @(posedge clk); #2 rst = 1'b0;
    check_reset_a("abort");
    chk("abort no write", cap_a.size(), 0);

    gen_random(4, 21);
    run_session(0, "after_abort");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
